s27_seq_ctrl: RTL and testbench

Test-sequencing controller for the s27 locked benchmark core.
- Holds the core in reset for a programmed number of cycles.
- Streams a programmed number of 4-bit input vectors (G0..G3) into the core over a valid/ready handshake.
- Gates the core clock so the core advances only on accepted vectors.
- Compacts the core output G17 into a MISR signature used for unlock/equivalence checks.
- Sits between the bench/key-evaluation harness and the s27 instance.

---
 rtl/s27_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_s27_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/s27_seq_ctrl.sv
// Test-sequencing controller for the s27 locked benchmark core.
// Holds the core in reset, streams input vectors over valid/ready with a
// gated core clock, and compacts G17 into a MISR signature.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; core held in reset
// CRST  | core reset with clock enabled for RST_CYCLES cycles
// RUN   | accepting vectors; core advances on each accepted vector
// DONE  | one-cycle completion; signature published
module s27_seq_ctrl #(
   parameter int              RST_CYCLES = 2,
   parameter int              VEC_W      = 4,
   parameter int              SIG_W      = 8,
   parameter logic [SIG_W-1:0] POLY      = 8'h1D,
   parameter logic [SIG_W-1:0] SEED      = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       num_vec,
   input  logic             vec_valid,
   input  logic [VEC_W-1:0] vec_data,
   output logic             vec_ready,
   output logic             core_rst,
   output logic             core_ce,
   output logic [VEC_W-1:0] core_in,
   input  logic             core_out,
   output logic             busy,
   output logic             done,
   output logic             sig_valid,
   output logic [SIG_W-1:0] signature
);

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CRST = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [RCW-1:0]   rst_cnt;
   logic [7:0]       vec_cnt;
   logic [7:0]       num_q;
   logic [SIG_W-1:0] misr;
   logic [SIG_W-1:0] misr_nxt;
   logic             sig_v_q;
   logic             fire;

   // MISR step: shift, polynomial feedback on the outgoing bit, fold in G17
   assign misr_nxt = {misr[SIG_W-2:0], 1'b0}
                   ^ (misr[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, core_out};

   // The MISR is frozen outside RUN, so it doubles as the published signature
   assign signature = misr;
   assign sig_valid = sig_v_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state and output decode; vec_ready depends on state only
   always_comb begin
      state_nxt = state;
      vec_ready = 1'b0;
      core_rst  = 1'b0;
      core_ce   = 1'b0;
      core_in   = '0;
      busy      = 1'b1;
      done      = 1'b0;
      fire      = 1'b0;
      case (state)
         S_IDLE: begin
            core_rst = 1'b1;
            busy     = 1'b0;
            if (start) state_nxt = S_CRST;
         end
         S_CRST: begin
            core_rst = 1'b1;
            core_ce  = 1'b1;
            if (rst_cnt == '0) state_nxt = (num_q == 8'd0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            vec_ready = 1'b1;
            fire      = vec_valid;
            core_ce   = vec_valid;
            if (vec_valid) core_in = vec_data;
            if (vec_valid && (vec_cnt == num_q - 8'd1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Run datapath: reset timer, vector count, MISR and signature-valid flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_cnt <= '0;
         vec_cnt <= 8'd0;
         num_q   <= 8'd0;
         misr    <= SEED;
         sig_v_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  num_q   <= num_vec;
                  misr    <= SEED;
                  sig_v_q <= 1'b0;
                  vec_cnt <= 8'd0;
                  rst_cnt <= RCW'(RST_CYCLES - 1);
               end
            end
            S_CRST: begin
               if (rst_cnt != '0) rst_cnt <= rst_cnt - RCW'(1);
            end
            S_RUN: begin
               if (fire) begin
                  misr    <= misr_nxt;
                  vec_cnt <= vec_cnt + 8'd1;
               end
            end
            default: ;
         endcase
         if (state != S_DONE && state_nxt == S_DONE) sig_v_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_s27_seq_ctrl.sv
// Randomized bench for s27_seq_ctrl with a behavioural MISR/sequencing model.
module tb_s27_seq_ctrl;

   localparam int RSTC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] num_vec = 8'd0;
   logic       vec_valid = 1'b0;
   logic [3:0] vec_data = 4'd0;
   logic       vec_ready;
   logic       core_rst;
   logic       core_ce;
   logic [3:0] core_in;
   logic       core_out = 1'b0;
   logic       busy;
   logic       done;
   logic       sig_valid;
   logic [7:0] signature;

   int total = 0;
   int bad   = 0;

   logic [3:0] vq [256];
   bit         oq [256];

   s27_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
      .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
      .core_rst(core_rst), .core_ce(core_ce), .core_in(core_in),
      .core_out(core_out), .busy(busy), .done(done),
      .sig_valid(sig_valid), .signature(signature)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference MISR: doubling mod 256, polynomial when the top bit falls off
   function automatic int misr_ref(input int m, input bit b);
      int r;
      r = (m * 2) % 256;
      if (m >= 128) r = r ^ 'h1D;
      return r ^ int'(b);
   endfunction

   function automatic int misr_of(input int n);
      int m = 0;
      for (int i = 0; i < n; i++) m = misr_ref(m, oq[i]);
      return m;
   endfunction

   // Entered at a negedge (plus #1) with the DUT in IDLE; leaves the same way.
   // mode: 0 = no stalls, 1 = random stalls, 2 = three stall cycles before vector 3
   task automatic do_run(input int n, input int mode, input bit midstart, input int exp_sig);
      int m = 0;
      int i = 0;
      int guard = 0;
      int stall_left = 3;
      bit v;
      start   = 1'b1;
      num_vec = 8'(n);
      vec_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("sigv_clr", sig_valid, 0);
      for (int c = 0; c < RSTC; c++) begin
         chk("crst_rst", core_rst, 1);
         chk("crst_ce", core_ce, 1);
         chk("crst_rdy", vec_ready, 0);
         chk("crst_busy", busy, 1);
         @(negedge clk);
         #1;
      end
      while (i < n && guard < 4000) begin
         guard++;
         case (mode)
            0: v = 1'b1;
            1: v = ($urandom_range(0, 99) >= 30);
            default: begin
               v = !(i == 2 && stall_left > 0);
               if (!v) stall_left--;
            end
         endcase
         vec_valid = v;
         vec_data  = vq[i];
         core_out  = oq[i];
         start     = midstart && (i == 1);
         num_vec   = (midstart && i == 1) ? 8'd200 : 8'(n);
         #1;
         chk("run_rdy", vec_ready, 1);
         chk("run_rst", core_rst, 0);
         chk("run_ce", core_ce, v);
         chk("run_in", core_in, v ? vq[i] : 4'd0);
         chk("run_done", done, 0);
         chk("run_sig", signature, m);
         if (v) begin
            m = misr_ref(m, oq[i]);
            i++;
         end
         @(negedge clk);
      end
      if (guard >= 4000) chk("run_timeout", 1, 0);
      start = 1'b0;
      num_vec = 8'(n);
      vec_valid = 1'b0;
      #1;
      chk("done_pulse", done, 1);
      chk("done_sigv", sig_valid, 1);
      chk("done_sig", signature, exp_sig);
      chk("done_model", signature, m);
      chk("done_rdy", vec_ready, 0);
      chk("done_ce", core_ce, 0);
      @(negedge clk);
      #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rst", core_rst, 1);
      chk("idle_sigv", sig_valid, 1);
      chk("idle_sig", signature, exp_sig);
   endtask

   initial begin
      int n;
      #1;
      chk("rst_core_rst", core_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sig", signature, 0);
      chk("rst_sigv", sig_valid, 0);
      chk("rst_rdy", vec_ready, 0);
      chk("rst_ce", core_ce, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;

      // Basic run: 1,0,1
      for (int i = 0; i < 3; i++) vq[i] = 4'($urandom);
      oq[0] = 1; oq[1] = 0; oq[2] = 1;
      do_run(3, 0, 0, 'h05);

      // Feedback: all ones
      for (int i = 0; i < 9; i++) begin vq[i] = 4'($urandom); oq[i] = 1; end
      do_run(9, 0, 0, 'hE2);

      // Stall vs no stall on the same vectors
      for (int i = 0; i < 4; i++) begin vq[i] = 4'($urandom); oq[i] = 1'($urandom); end
      do_run(4, 2, 0, misr_of(4));
      do_run(4, 0, 0, misr_of(4));

      // Zero vectors
      do_run(0, 0, 0, 0);

      // Start during RUN ignored, then back-to-back runs
      for (int i = 0; i < 6; i++) begin vq[i] = 4'($urandom); oq[i] = 1'($urandom); end
      do_run(6, 1, 1, misr_of(6));
      do_run(6, 0, 0, misr_of(6));

      // Random runs
      for (int r = 0; r < 30; r++) begin
         n = $urandom_range(0, 20);
         for (int i = 0; i < n; i++) begin vq[i] = 4'($urandom); oq[i] = 1'($urandom); end
         do_run(n, 1, 0, misr_of(n));
      end

      // Longest run
      for (int i = 0; i < 255; i++) begin vq[i] = 4'($urandom); oq[i] = 1'($urandom); end
      do_run(255, 0, 0, misr_of(255));

      // Reset mid-RUN after two vectors
      start = 1'b1;
      num_vec = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (RSTC) @(negedge clk);
      vec_valid = 1'b1;
      core_out = 1'b1;
      vec_data = 4'hA;
      repeat (2) @(negedge clk);
      #1;
      chk("pre_rst_sig", signature, 'h03);
      rst = 1'b0;
      #1;
      chk("arst_core_rst", core_rst, 1);
      chk("arst_busy", busy, 0);
      chk("arst_sig", signature, 0);
      chk("arst_rdy", vec_ready, 0);
      chk("arst_ce", core_ce, 0);
      chk("arst_in", core_in, 0);
      chk("arst_sigv", sig_valid, 0);
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("arst_nodone", done, 0);
      end
      vec_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
